// File: rtl/cpu_pkg.sv
// Shared constants for the CPU-side RAM access path: bus widths, port ids
// and the access-controller state encoding.
package cpu_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_DATA  = 1'b1;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_RD_WAIT  = 3'd1;
   localparam logic [2:0] ST_RD_CAP   = 3'd2;
   localparam logic [2:0] ST_WR_SETUP = 3'd3;
   localparam logic [2:0] ST_WR_PULSE = 3'd4;
   localparam logic [2:0] ST_WR_HOLD  = 3'd5;
   localparam logic [2:0] ST_ACK      = 3'd6;

endpackage

// File: rtl/mem_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on contention
// the port that did not win last time is granted.
module mem_arb2
   import cpu_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       valid
);

   always_comb begin
      valid = |req;
      grant = PORT_FETCH;
      if (req == 2'b11)
         grant = ~last_grant;
      else if (req[PORT_DATA])
         grant = PORT_DATA;
   end

endmodule

// File: rtl/ram_access_ctrl.sv
// Initiator for the 256x16 program/data RAM: arbitrates fetch and data ports
// and sequences addr/din/we so the RAM never sees them move while we=1.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for a request; grant edge latches port and address
// RD_WAIT     | ram_addr held for RD_WAIT cycles while RAM output settles
// RD_CAP      | ram_dout captured into the granted port's data register
// WR_SETUP    | addr/din stable one cycle before raising ram_we
// WR_PULSE    | ram_we high for WR_PULSE cycles
// WR_HOLD     | ram_we low, addr/din held one more cycle
// ACK         | granted port's ack high for this one cycle
module ram_access_ctrl
   import cpu_pkg::*;
#(
   parameter int ADDR_W   = cpu_pkg::ADDR_W,
   parameter int DATA_W   = cpu_pkg::DATA_W,
   parameter int RD_WAIT  = 1,
   parameter int WR_PULSE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ack,
   output logic [DATA_W-1:0] fetch_data,
   input  logic              dat_req,
   input  logic              dat_we,
   input  logic [ADDR_W-1:0] dat_addr,
   input  logic [DATA_W-1:0] dat_wdata,
   output logic              dat_ack,
   output logic [DATA_W-1:0] dat_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy
);

   localparam int CNT_MAX = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);

   logic [2:0]       state;
   logic [CNT_W-1:0] wait_cnt;
   logic             port;
   logic             last_grant;
   logic             arb_grant;
   logic             arb_valid;
   logic [ADDR_W-1:0] gnt_addr;

   mem_arb2 u_arb (
      .req        ({dat_req, fetch_req}),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .valid      (arb_valid)
   );

   assign gnt_addr = (arb_grant == PORT_DATA) ? dat_addr : fetch_addr;
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         port       <= PORT_FETCH;
         last_grant <= PORT_FETCH;
         ram_addr   <= '0;
         ram_din    <= '0;
         ram_we     <= 1'b0;
         fetch_ack  <= 1'b0;
         dat_ack    <= 1'b0;
         fetch_data <= '0;
         dat_rdata  <= '0;
      end else begin
         fetch_ack <= 1'b0;
         dat_ack   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (arb_valid) begin
                  port       <= arb_grant;
                  last_grant <= arb_grant;
                  ram_addr   <= gnt_addr;
                  if (arb_grant == PORT_DATA && dat_we) begin
                     ram_din <= dat_wdata;
                     state   <= ST_WR_SETUP;
                  end else begin
                     wait_cnt <= RD_LOAD;
                     state    <= ST_RD_WAIT;
                  end
               end
            end
            ST_RD_WAIT: begin
               if (wait_cnt == '0)
                  state <= ST_RD_CAP;
               else
                  wait_cnt <= wait_cnt - CNT_W'(1);
            end
            ST_RD_CAP: begin
               if (port == PORT_DATA) begin
                  dat_rdata <= ram_dout;
                  dat_ack   <= 1'b1;
               end else begin
                  fetch_data <= ram_dout;
                  fetch_ack  <= 1'b1;
               end
               state <= ST_ACK;
            end
            ST_WR_SETUP: begin
               ram_we   <= 1'b1;
               wait_cnt <= WR_LOAD;
               state    <= ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
               if (wait_cnt == '0) begin
                  ram_we <= 1'b0;
                  state  <= ST_WR_HOLD;
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
               end
            end
            ST_WR_HOLD: begin
               // only the data port can reach a write
               dat_ack <= 1'b1;
               state   <= ST_ACK;
            end
            ST_ACK: begin
               state <= ST_IDLE;
            end
            default: begin
               ram_we <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: behavioural RAM, reference memory scoreboard
// and a bus monitor for write-strobe stability and ack exclusivity.
module tb_ram_access_ctrl;
   import cpu_pkg::*;

   localparam int RD_WAIT_P  = 1;
   localparam int WR_PULSE_P = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req, dat_req, dat_we;
   logic [7:0]  fetch_addr, dat_addr;
   logic [15:0] dat_wdata;
   logic        fetch_ack, dat_ack, ram_we, busy;
   logic [15:0] fetch_data, dat_rdata, ram_din, ram_dout;
   logic [7:0]  ram_addr;

   logic [15:0] ram_mem [256];
   logic [15:0] ref_mem [256];

   typedef struct {
      logic        port;
      logic [15:0] data;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;
   int n_acks   = 0;
   int we_cycles = 0;
   logic [7:0]  we_addr, prev_addr;
   logic [15:0] we_din, prev_din;

   always #5 clk = ~clk;

   ram_access_ctrl #(
      .ADDR_W(8), .DATA_W(16), .RD_WAIT(RD_WAIT_P), .WR_PULSE(WR_PULSE_P)
   ) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ack(fetch_ack), .fetch_data(fetch_data),
      .dat_req(dat_req), .dat_we(dat_we), .dat_addr(dat_addr),
      .dat_wdata(dat_wdata), .dat_ack(dat_ack), .dat_rdata(dat_rdata),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
      .ram_dout(ram_dout), .busy(busy)
   );

   assign ram_dout = ram_mem[ram_addr];
   always @(posedge clk) if (ram_we) ram_mem[ram_addr] <= ram_din;

   always @(negedge clk) begin
      if (!rst) begin
         if (ram_we) begin
            n_checks++;
            if (ram_addr !== prev_addr || ram_din !== prev_din)
               $display("FAIL we_stable: addr %h->%h din %h->%h while ram_we=1",
                        prev_addr, ram_addr, prev_din, ram_din);
            else n_pass++;
            we_cycles++;
            we_addr = ram_addr;
            we_din  = ram_din;
         end
         if (fetch_ack || dat_ack) begin
            n_acks++;
            n_checks++;
            if (fetch_ack && dat_ack)
               $display("FAIL ack_exclusive: fetch_ack=%b dat_ack=%b required not both", fetch_ack, dat_ack);
            else n_pass++;
         end
      end
      prev_addr = ram_addr;
      prev_din  = ram_din;
   end

   task automatic do_op(input logic port, input logic we, input logic [7:0] addr,
                        input logic [15:0] wdata);
      exp_t e;
      int   n;
      bit   got;
      logic ack_port;
      e.port = port;
      e.data = we ? wdata : ref_mem[addr];
      if (we) ref_mem[addr] = wdata;
      sb.push_back(e);
      if (port == PORT_FETCH) begin
         fetch_req = 1'b1; fetch_addr = addr;
      end else begin
         dat_req = 1'b1; dat_we = we; dat_addr = addr; dat_wdata = wdata;
      end
      n = 0; got = 0;
      while (!got && n < 20) begin
         @(posedge clk); #1; n++;
         if (fetch_ack || dat_ack) got = 1;
      end
      n_checks++;
      if (!got) begin
         $display("FAIL op_timeout: no ack after %0d cycles, required ack for addr %h", n, addr);
         void'(sb.pop_front());
      end else begin
         n_pass++;
         e = sb.pop_front();
         ack_port = dat_ack;
         n_checks++;
         if (ack_port !== e.port)
            $display("FAIL ack_port: got port %b required %b", ack_port, e.port);
         else n_pass++;
         n_checks++;
         if (n !== (we ? WR_PULSE_P + 3 : RD_WAIT_P + 2))
            $display("FAIL latency: got %0d required %0d", n, we ? WR_PULSE_P + 3 : RD_WAIT_P + 2);
         else n_pass++;
         if (!we) begin
            n_checks++;
            if ((port ? dat_rdata : fetch_data) !== e.data)
               $display("FAIL read_data: addr %h got %h required %h",
                        addr, port ? dat_rdata : fetch_data, e.data);
            else n_pass++;
         end
      end
      @(posedge clk); #1;
      fetch_req = 1'b0; dat_req = 1'b0; dat_we = 1'b0;
      n_checks++;
      if ((fetch_ack | dat_ack) !== 1'b0)
         $display("FAIL ack_width: ack still high %b%b required 00", fetch_ack, dat_ack);
      else n_pass++;
   endtask

   task automatic test_reset_init();
      n_checks++;
      if ({ram_we, ram_addr, ram_din, fetch_ack, dat_ack, fetch_data, dat_rdata, busy} !== '0)
         $display("FAIL reset_init: we=%b addr=%h din=%h acks=%b%b fd=%h dr=%h busy=%b required all 0",
                  ram_we, ram_addr, ram_din, fetch_ack, dat_ack, fetch_data, dat_rdata, busy);
      else n_pass++;
   endtask

   task automatic test_fetch();
      do_op(PORT_FETCH, 1'b0, 8'h00, 16'h0000);
   endtask

   task automatic test_write_read();
      int we0;
      we0 = we_cycles;
      do_op(PORT_DATA, 1'b1, 8'hFF, 16'h1234);
      n_checks++;
      if (we_cycles - we0 !== 1 || we_addr !== 8'hFF || we_din !== 16'h1234)
         $display("FAIL write_pulse: cycles=%0d addr=%h din=%h required 1 FF 1234",
                  we_cycles - we0, we_addr, we_din);
      else n_pass++;
      do_op(PORT_DATA, 1'b0, 8'hFF, 16'h0000);
   endtask

   task automatic test_reset();
      int n;
      // rewrite the preloaded value so an aborted pulse leaves memory unchanged
      dat_req = 1'b1; dat_we = 1'b1; dat_addr = 8'h10; dat_wdata = ref_mem[8'h10];
      n = 0;
      while (ram_we !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
      n_checks++;
      if (ram_we !== 1'b1) $display("FAIL reset_reach_pulse: ram_we=%b required 1", ram_we);
      else n_pass++;
      rst = 1'b1; dat_req = 1'b0; dat_we = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (ram_we !== 1'b0) $display("FAIL reset_we: ram_we=%b required 0", ram_we);
      else n_pass++;
      n_checks++;
      if ({ram_addr, ram_din, fetch_ack, dat_ack, fetch_data, dat_rdata, busy} !== '0)
         $display("FAIL reset_outputs: addr=%h din=%h acks=%b%b fd=%h dr=%h busy=%b required all 0",
                  ram_addr, ram_din, fetch_ack, dat_ack, fetch_data, dat_rdata, busy);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic run_contention(input int nacks, input bit hold);
      exp_t e;
      int   seen, cyc;
      logic got_port;
      seen = 0; cyc = 0;
      for (int i = 0; i < nacks; i++) begin
         e.port = (i % 2 == 0) ? PORT_DATA : PORT_FETCH;
         e.data = e.port ? ref_mem[8'h02] : ref_mem[8'h01];
         sb.push_back(e);
      end
      fetch_addr = 8'h01; dat_addr = 8'h02; dat_we = 1'b0;
      fetch_req = 1'b1; dat_req = 1'b1;
      while (seen < nacks && cyc < 100) begin
         @(posedge clk); #1; cyc++;
         if (fetch_ack || dat_ack) begin
            got_port = dat_ack;
            e = sb.pop_front();
            seen++;
            n_checks++;
            if (got_port !== e.port)
               $display("FAIL grant_order: ack %0d got port %b required %b", seen, got_port, e.port);
            else n_pass++;
            n_checks++;
            if ((got_port ? dat_rdata : fetch_data) !== e.data)
               $display("FAIL contention_data: got %h required %h",
                        got_port ? dat_rdata : fetch_data, e.data);
            else n_pass++;
            @(posedge clk); #1; cyc++;
            if (!hold) begin
               if (got_port) dat_req = 1'b0; else fetch_req = 1'b0;
            end
         end
      end
      n_checks++;
      if (seen !== nacks) $display("FAIL contention_count: got %0d acks required %0d", seen, nacks);
      else n_pass++;
      fetch_req = 1'b0; dat_req = 1'b0;
      sb.delete();
   endtask

   task automatic test_contention();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      run_contention(2, 1'b0);
      run_contention(6, 1'b1);
   endtask

   task automatic test_back_to_back();
      int a0;
      a0 = n_acks;
      for (int i = 1; i <= 5; i++) do_op(PORT_FETCH, 1'b0, 8'(i), 16'h0000);
      n_checks++;
      if (n_acks - a0 !== 5) $display("FAIL b2b_ack_count: got %0d required 5", n_acks - a0);
      else n_pass++;
   endtask

   task automatic test_random();
      logic p, w;
      for (int i = 0; i < 40; i++) begin
         p = 1'($urandom_range(0, 1));
         w = p ? 1'($urandom_range(0, 1)) : 1'b0;
         do_op(p, w, 8'($urandom_range(0, 255)), 16'($urandom));
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 16'h0101) ^ 16'h3C5A;
      ref_mem[0] = 16'hA006;
      for (int i = 0; i < 256; i++) ram_mem[i] = ref_mem[i];
      rst = 1'b1; fetch_req = 1'b0; dat_req = 1'b0; dat_we = 1'b0;
      fetch_addr = '0; dat_addr = '0; dat_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      test_reset_init();
      test_fetch();
      test_write_read();
      test_reset();
      test_contention();
      test_back_to_back();
      test_random();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
